// File: rtl/fb_double_buffer_if.sv
// rtl/fb_double_buffer_if.sv - control, draw-port and scan-out-port bundle for fb_double_buffer
interface fb_double_buffer_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 4
);
  // buffer swap / clear control
  logic               flip_req;
  logic               vblank;
  logic               flip_ack;
  logic               front_sel;
  logic               clr_req;
  logic               clr_busy;

  // drawing-engine write port (back buffer)
  logic               wr_en;
  logic [X_W-1:0]     wr_x;
  logic [Y_W-1:0]     wr_y;
  logic [COLOR_W-1:0] wr_c;
  logic               wr_ready;
  logic               wr_err;

  // scan-out read port (front buffer)
  logic               rd_en;
  logic [X_W-1:0]     rd_x;
  logic [Y_W-1:0]     rd_y;
  logic [COLOR_W-1:0] rd_c;
  logic               rd_vld;

  modport master (
    output flip_req, vblank, clr_req,
    output wr_en, wr_x, wr_y, wr_c,
    output rd_en, rd_x, rd_y,
    input  flip_ack, front_sel, clr_busy,
    input  wr_ready, wr_err,
    input  rd_c, rd_vld
  );

  modport slave (
    input  flip_req, vblank, clr_req,
    input  wr_en, wr_x, wr_y, wr_c,
    input  rd_en, rd_x, rd_y,
    output flip_ack, front_sel, clr_busy,
    output wr_ready, wr_err,
    output rd_c, rd_vld
  );
endinterface

// File: rtl/fb_double_buffer.sv
// rtl/fb_double_buffer.sv - double-buffered framebuffer with vblank-gated flip and back-buffer clear sweep
module fb_double_buffer #(
  parameter int                 DISP_WIDTH  = 640,
  parameter int                 DISP_HEIGHT = 480,
  parameter int                 X_W         = 10,
  parameter int                 Y_W         = 9,
  parameter int                 COLOR_W     = 4,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  fb_double_buffer_if.slave bus
);

  localparam int NPIX = DISP_WIDTH * DISP_HEIGHT;
  localparam int A_W  = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic               flip_pend;
  logic               clr_pend;
  logic               clr_tgt;     // buffer being swept: 0 = A, 1 = B
  logic               front_sel;
  logic               flip_ack;
  logic               wr_err;
  logic [X_W-1:0]     cx;
  logic [Y_W-1:0]     cy;
  logic [COLOR_W-1:0] rd_c;
  logic               rd_vld;

  // Pixel storage has no reset; the declaration value gives the power-up image.
  logic [COLOR_W-1:0] mem_a [NPIX] = '{default: CLEAR_COLOR};
  logic [COLOR_W-1:0] mem_b [NPIX] = '{default: CLEAR_COLOR};

  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < 32'(DISP_WIDTH)) && (32'(y) < 32'(DISP_HEIGHT));
  endfunction

  function automatic logic [A_W-1:0] addr_of(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return A_W'(32'(y) * 32'(DISP_WIDTH) + 32'(x));
  endfunction

  logic           idle;
  logic           flip_go;
  logic           clr_go;
  logic           wr_ok;
  logic           x_last;
  logic           clr_last;
  logic [A_W-1:0] wr_addr;
  logic [A_W-1:0] rd_addr;
  logic [A_W-1:0] clr_addr;

  assign idle     = (state == IDLE);
  // A flip has priority over a clear that becomes eligible in the same cycle;
  // the clear then starts one cycle later against the new back buffer.
  assign flip_go  = idle && (flip_pend || bus.flip_req) && bus.vblank;
  assign clr_go   = idle && (clr_pend || bus.clr_req) && !flip_go;
  assign wr_ok    = bus.wr_en && idle && in_range(bus.wr_x, bus.wr_y);
  assign x_last   = (32'(cx) == 32'(DISP_WIDTH - 1));
  assign clr_last = x_last && (32'(cy) == 32'(DISP_HEIGHT - 1));
  assign wr_addr  = addr_of(bus.wr_x, bus.wr_y);
  assign rd_addr  = addr_of(bus.rd_x, bus.rd_y);
  assign clr_addr = addr_of(cx, cy);

  assign bus.front_sel = front_sel;
  assign bus.flip_ack  = flip_ack;
  assign bus.clr_busy  = (state == CLEAR);
  assign bus.wr_ready  = idle;
  assign bus.wr_err    = wr_err;
  assign bus.rd_c      = rd_c;
  assign bus.rd_vld    = rd_vld;

  // Control FSM: pending flags, flip commit, clear sweep counters and write-drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flip_pend <= 1'b0;
      clr_pend  <= 1'b0;
      clr_tgt   <= 1'b0;
      front_sel <= 1'b0;
      flip_ack  <= 1'b0;
      wr_err    <= 1'b0;
      cx        <= '0;
      cy        <= '0;
    end else begin
      flip_ack <= flip_go;
      wr_err   <= bus.wr_en && !wr_ok;

      if (flip_go) begin
        front_sel <= ~front_sel;
        flip_pend <= 1'b0;
      end else if (bus.flip_req) begin
        flip_pend <= 1'b1;
      end

      if (clr_go) begin
        clr_pend <= 1'b0;
      end else if (bus.clr_req) begin
        clr_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (clr_go) begin
            state   <= CLEAR;
            cx      <= '0;
            cy      <= '0;
            clr_tgt <= ~front_sel;
          end
        end
        CLEAR: begin
          if (clr_last) begin
            state <= IDLE;
          end else if (x_last) begin
            cx <= '0;
            cy <= cy + Y_W'(1);
          end else begin
            cx <= cx + X_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer A writes: the sweep owns the buffer while clearing; otherwise drawing writes land here when B is front.
  always_ff @(posedge clk) begin
    if ((state == CLEAR) && !clr_tgt) begin
      mem_a[clr_addr] <= CLEAR_COLOR;
    end else if (wr_ok && front_sel) begin
      mem_a[wr_addr] <= bus.wr_c;
    end
  end

  // Buffer B writes: mirror of buffer A with the roles swapped.
  always_ff @(posedge clk) begin
    if ((state == CLEAR) && clr_tgt) begin
      mem_b[clr_addr] <= CLEAR_COLOR;
    end else if (wr_ok && !front_sel) begin
      mem_b[wr_addr] <= bus.wr_c;
    end
  end

  // Scan-out read: one-cycle latency from the current front buffer, never stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_c   <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= bus.rd_en;
      if (bus.rd_en) begin
        if (!in_range(bus.rd_x, bus.rd_y)) begin
          rd_c <= CLEAR_COLOR;
        end else if (front_sel) begin
          rd_c <= mem_b[rd_addr];
        end else begin
          rd_c <= mem_a[rd_addr];
        end
      end
    end
  end

endmodule

// File: doc/fb_double_buffer.md
# fb_double_buffer

Parametrised double-buffered framebuffer. Supports any resolution and colour depth. Flips between buffers are requested asynchronously to the frame and committed only during vertical blanking. A hardware sweep clears the back buffer to a constant colour. The block sits between the drawing engine (write port) and the pixel scan-out (read port): the drawing engine always writes the back buffer, and scan-out always reads the front buffer.

## Interface
- DISP_WIDTH, 640, pixels per line
- DISP_HEIGHT, 480, lines per frame
- X_W, 10, width of x coordinates; must satisfy 2**X_W >= DISP_WIDTH
- Y_W, 9, width of y coordinates; must satisfy 2**Y_W >= DISP_HEIGHT
- COLOR_W, 4, bits per pixel
- CLEAR_COLOR, 0, value written by the clear sweep and returned for out-of-range reads

Ports:
- clk  in  1  sole clock; all logic is posedge
- rst_n  in  1  asynchronous, active-low reset
- flip_req  in  1  single-cycle request to swap front and back buffers
- vblank  in  1  high while scan-out is in vertical blanking
- flip_ack  out  1  one-cycle pulse in the cycle after a flip commits
- front_sel  out  1  0: buffer A is front; 1: buffer B is front
- clr_req  in  1  single-cycle request to clear the back buffer
- clr_busy  out  1  high while a clear sweep is running
- wr_en  in  1  write strobe
- wr_x  in  X_W  write x coordinate
- wr_y  in  Y_W  write y coordinate
- wr_c  in  COLOR_W  write colour
- wr_ready  out  1  equals ~clr_busy; writes presented while it is low are dropped
- wr_err  out  1  one-cycle pulse for a dropped write (out of range, or during a clear)
- rd_en  in  1  read strobe
- rd_x  in  X_W  read x coordinate
- rd_y  in  Y_W  read y coordinate
- rd_c  out  COLOR_W  read data
- rd_vld  out  1  read data valid

## Operation

**Storage**
- Two DISP_HEIGHT x DISP_WIDTH x COLOR_W arrays, A and B.
- Arrays are not reset.
- Power-up contents are CLEAR_COLOR.

**Write port**
- Qualification: wr_en && wr_ready && wr_x < DISP_WIDTH && wr_y < DISP_HEIGHT.
- A qualified write updates the back buffer (~front_sel, sampled in the same cycle).
- Any other cycle with wr_en high is dropped and pulses wr_err in the next cycle.

**Read port**
- Reads always come from the front buffer, sampled in the rd_en cycle.
- In range: rd_c is the stored pixel. Out of range: rd_c is CLEAR_COLOR.
- Reads are never blocked: they are served during clears and across flips.

**FSM states**
- IDLE: no clear in progress.
- CLEAR: sweep in progress.

**Pending flags**
- flip_pend is set by flip_req.
- clr_pend is set by clr_req.
- Each flag is cleared only when its operation is consumed.
- Repeated requests while a flag is already set are absorbed; nothing queues beyond one.

**Flip commit**
- Condition: IDLE && (flip_pend || flip_req) && vblank.
- Effect: toggle front_sel, clear flip_pend, pulse flip_ack in the next cycle.
- A flip is never committed in CLEAR; it stays pending until the sweep finishes and vblank is high.

**Clear start**
- Condition: IDLE && (clr_pend || clr_req) && no flip commit in the same cycle.
- Effect: go to CLEAR with the counters at (x=0, y=0), clear clr_pend, and latch the target buffer (~front_sel at start).
- A flip and a clear eligible in the same cycle: the flip wins. The clear starts in the next cycle, on the new back buffer.

**CLEAR state**
- Writes CLEAR_COLOR to one pixel per cycle, in raster order (x increments first, wraps to 0, then y increments).
- After writing (DISP_WIDTH-1, DISP_HEIGHT-1), returns to IDLE.

**Reset**
- Asserting rst_n mid-sweep aborts the sweep immediately; memory is left partially cleared.
- Asserting rst_n mid-sweep also drops both pending flags.

## Timing

**Reset values**
- front_sel=0, flip_ack=0, clr_busy=0, wr_ready=1, wr_err=0, rd_c=0, rd_vld=0.
- State IDLE, both pending flags 0.

**Read path**
- Latency is 1 cycle: rd_en at cycle N gives rd_vld=1 and rd_c valid at N+1.
- When rd_en is low, rd_vld=0 in the next cycle and rd_c holds its previous value.

**Write path**
- A write at cycle N is visible to the read port from cycle N+1, but only after a flip makes that buffer the front buffer.

**Flip**
- Commit in cycle N: front_sel changes at N+1 and flip_ack pulses at N+1.
- A read issued at N uses the old front buffer.
- A write at N goes to the old back buffer.

**Clear**
- clr_req at N (with no competing flip): clr_busy=1 and wr_ready=0 from N+1.
- The sweep lasts exactly DISP_WIDTH*DISP_HEIGHT cycles.
- clr_busy falls in the cycle after the last pixel is written.

**Same-pixel collisions**
- A read and a write to the same pixel in the same cycle never collide, because they target different buffers.

## Test plan
- Reset, then read (3,4) -> rd_vld=1 one cycle later, rd_c=CLEAR_COLOR, front_sel=0.
- Write (5,5)=0xA; read (5,5) -> 0x0. Pulse flip_req with vblank=0 -> no flip_ack. Raise vblank -> flip_ack 1 cycle later, front_sel=1, read (5,5) -> 0xA.
- Write to (DISP_WIDTH,0) and to (0,DISP_HEIGHT) -> wr_err pulses, and neither buffer changes (both reads return CLEAR_COLOR before and after a flip).
- Fill the back buffer with 0x7, then pulse clr_req -> clr_busy high for exactly DISP_WIDTH*DISP_HEIGHT cycles. A write during the sweep -> wr_err. After a flip, every pixel reads CLEAR_COLOR.
- Pulse flip_req during a clear with vblank=1 held throughout -> front_sel does not change until clr_busy falls, then flips on the next cycle.
- Pulse clr_req and a committing flip in the same cycle -> front_sel toggles first, and the clear then sweeps the new back buffer. Assert rst_n mid-sweep -> clr_busy=0 and front_sel=0 immediately.
